// File: rtl/mux_pkg.sv
// Shared select encodings and lane geometry for the 4:1 mux.
package mux_pkg;

  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned SEL_W     = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_L0 = 2'd0;
  localparam sel_t SEL_L1 = 2'd1;
  localparam sel_t SEL_L2 = 2'd2;
  localparam sel_t SEL_L3 = 2'd3;

endpackage : mux_pkg

// File: rtl/mux4x1_if.sv
// Data-side bundle of the 4:1 mux: select, packed lanes and both outputs.
interface mux4x1_if #(
  parameter int unsigned WIDTH = 1
);
  import mux_pkg::*;

  sel_t                         sel;
  logic [NUM_LANES*WIDTH-1:0]   din;
  logic [WIDTH-1:0]             dout;
  logic [WIDTH-1:0]             dout_q;

  // Driver side: supplies select and lanes, observes outputs.
  modport master (
    output sel,
    output din,
    input  dout,
    input  dout_q
  );

  // Mux side.
  modport slave (
    input  sel,
    input  din,
    output dout,
    output dout_q
  );

endinterface : mux4x1_if

// File: rtl/mux_lane_sel.sv
// Purely combinational lane extractor: returns lane sel_i of the packed din_i.
module mux_lane_sel
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  sel_t                       sel_i,
  input  logic [NUM_LANES*WIDTH-1:0] din_i,
  output logic [WIDTH-1:0]           lane_o
);

  // Every encoding maps to a lane; the zero default only keeps the block latch-free.
  always_comb begin
    lane_o = '0;
    case (sel_i)
      SEL_L0:  lane_o = din_i[0*WIDTH +: WIDTH];
      SEL_L1:  lane_o = din_i[1*WIDTH +: WIDTH];
      SEL_L2:  lane_o = din_i[2*WIDTH +: WIDTH];
      SEL_L3:  lane_o = din_i[3*WIDTH +: WIDTH];
      default: lane_o = '0;
    endcase
  end

endmodule : mux_lane_sel

// File: rtl/mux4x1.sv
// 4:1 mux with a registered copy of the selection; REG_OUT picks which one drives dout.
module mux4x1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter bit          REG_OUT = 1'b0
) (
  input logic      clk,
  input logic      rst,
  mux4x1_if.slave  bus
);

  logic [WIDTH-1:0] sel_lane;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  mux_lane_sel #(
    .WIDTH (WIDTH)
  ) u_lane_sel (
    .sel_i  (bus.sel),
    .din_i  (bus.din),
    .lane_o (sel_lane)
  );

  // Next state: zero under reset so an unknown select cannot reach the register.
  always_comb begin
    data_d = sel_lane;
    if (rst) begin
      data_d = '0;
    end
  end

  // Output register, one cycle behind the combinational selection.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign bus.dout_q = data_q;

  if (REG_OUT) begin : g_reg_out
    assign bus.dout = data_q;
  end else begin : g_comb_out
    assign bus.dout = sel_lane;
  end

endmodule : mux4x1

// File: tb/tb_mux4x1.sv
// Self-checking bench: combinational vector table on a 1-bit mux, hand-written
// reset/registered sequences, and an 8-bit registered-output instance.
module tb_mux4x1;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mux4x1_if #(.WIDTH(1)) bus_a ();
  mux4x1_if #(.WIDTH(8)) bus_b ();

  mux4x1 #(
    .WIDTH   (1),
    .REG_OUT (1'b0)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  mux4x1 #(
    .WIDTH   (8),
    .REG_OUT (1'b1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    logic [1:0] sel;
    logic [3:0] din;
    logic       exp;
  } vec_t;

  vec_t vecs [16];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    logic       prev_a;
    logic [7:0] lanes_b [4];
    logic [7:0] prev_b;

    vecs[0]  = '{2'b11, 4'b0000, 1'b0};
    vecs[1]  = '{2'b11, 4'b1000, 1'b1};
    vecs[2]  = '{2'b11, 4'b1110, 1'b1};
    vecs[3]  = '{2'b11, 4'b0101, 1'b0};
    vecs[4]  = '{2'b10, 4'b0101, 1'b1};
    vecs[5]  = '{2'b10, 4'b0010, 1'b0};
    vecs[6]  = '{2'b10, 4'b1011, 1'b0};
    vecs[7]  = '{2'b10, 4'b0101, 1'b1};
    vecs[8]  = '{2'b01, 4'b0101, 1'b0};
    vecs[9]  = '{2'b01, 4'b0001, 1'b0};
    vecs[10] = '{2'b01, 4'b0110, 1'b1};
    vecs[11] = '{2'b01, 4'b0100, 1'b0};
    vecs[12] = '{2'b00, 4'b0100, 1'b0};
    vecs[13] = '{2'b00, 4'b1000, 1'b0};
    vecs[14] = '{2'b00, 4'b1110, 1'b0};
    vecs[15] = '{2'b00, 4'b0101, 1'b1};

    lanes_b[0] = 8'hAA;
    lanes_b[1] = 8'hBB;
    lanes_b[2] = 8'hCC;
    lanes_b[3] = 8'hDD;

    rst       = 1'b1;
    bus_a.sel = SEL_L0;
    bus_a.din = '0;
    bus_b.sel = SEL_L0;
    bus_b.din = '0;

    // Reset state after two reset edges.
    @(negedge clk);
    @(negedge clk);
    check("rst_a_dout_q", 32'(bus_a.dout_q), 32'd0);
    check("rst_b_dout_q", 32'(bus_b.dout_q), 32'd0);
    check("rst_b_dout",   32'(bus_b.dout),   32'd0);

    // Vector table: combinational result right away, registered one edge later.
    rst    = 1'b0;
    prev_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d_dout_q_prev", i), 32'(bus_a.dout_q), 32'(prev_a));
      bus_a.sel = vecs[i].sel;
      bus_a.din = vecs[i].din;
      #1;
      check($sformatf("vec%0d_dout", i), 32'(bus_a.dout), 32'(vecs[i].exp));
      prev_a = vecs[i].exp;
    end
    @(negedge clk);
    check("vec_last_dout_q", 32'(bus_a.dout_q), 32'(prev_a));

    // Registered path with reset: two reset cycles clear dout_q.
    rst = 1'b1;
    @(negedge clk);
    check("seq_rst1_dout_q", 32'(bus_a.dout_q), 32'd0);
    @(negedge clk);
    check("seq_rst2_dout_q", 32'(bus_a.dout_q), 32'd0);

    // First edge after release captures the current selection.
    rst       = 1'b0;
    bus_a.sel = SEL_L3;
    bus_a.din = 4'b1000;
    #1;
    check("seq_sel3_comb", 32'(bus_a.dout), 32'd1);
    check("seq_sel3_q_before_edge", 32'(bus_a.dout_q), 32'd0);
    @(negedge clk);
    check("seq_sel3_q_after_edge", 32'(bus_a.dout_q), 32'd1);

    // A mid-cycle input change must not reach dout_q before the next edge.
    bus_a.din = 4'b0000;
    #1;
    check("seq_midcycle_comb", 32'(bus_a.dout), 32'd0);
    check("seq_midcycle_q_hold", 32'(bus_a.dout_q), 32'd1);
    @(negedge clk);
    check("seq_midcycle_q_next", 32'(bus_a.dout_q), 32'd0);

    bus_a.din = 4'b1000;
    @(negedge clk);
    check("seq_reload_q", 32'(bus_a.dout_q), 32'd1);

    // Reset asserted together with a new select: comb path ignores reset, register clears.
    rst       = 1'b1;
    bus_a.sel = SEL_L0;
    bus_a.din = 4'b0001;
    #1;
    check("seq_rst_comb_unaffected", 32'(bus_a.dout), 32'd1);
    @(negedge clk);
    check("seq_rst_mid_q", 32'(bus_a.dout_q), 32'd0);
    check("seq_rst_mid_comb", 32'(bus_a.dout), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("seq_rst_release_q", 32'(bus_a.dout_q), 32'd1);

    // 8-bit registered output: each lane appears one edge after its select.
    bus_b.din = 32'hDDCC_BBAA;
    prev_b    = 8'h00;
    for (int k = 0; k < 4; k++) begin
      bus_b.sel = sel_t'(k);
      #1;
      check($sformatf("b_sel%0d_before_edge", k), 32'(bus_b.dout), 32'(prev_b));
      @(negedge clk);
      check($sformatf("b_sel%0d_dout", k), 32'(bus_b.dout), 32'(lanes_b[k]));
      check($sformatf("b_sel%0d_dout_q", k), 32'(bus_b.dout_q), 32'(lanes_b[k]));
      prev_b = lanes_b[k];
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule : tb_mux4x1
